// File: rtl/qpsk_timing_control_mc_if.sv
// ---------------------------------------------------------------------------
// qpsk_timing_control_mc_if
// Bundles the strobes and status outputs of the QPSK timing controller.
//   sample_pulse       : one-cycle CIC output strobe
//   one_sec_pulse      : PPS level, already synchronised to clk
//   enable             : 0 freezes the controller
//   cic_pulse_counter  : running sample count since last PPS edge
//   captured_count     : sample count of the previous complete second
//   capture_valid      : one-cycle strobe, captured_count updated
//   write              : one-cycle symbol-slot strobe
//   slot_index         : slot number since last PPS edge
//   pps_locked         : PPS qualified
//   pps_missing        : count overran the tolerance window without PPS
// master drives the inputs (stimulus side), slave is the controller.
// ---------------------------------------------------------------------------
interface qpsk_timing_control_mc_if #(
    parameter int CNT_W  = 16,
    parameter int SLOT_W = 10
);
    logic              sample_pulse;
    logic              one_sec_pulse;
    logic              enable;
    logic [CNT_W-1:0]  cic_pulse_counter;
    logic [CNT_W-1:0]  captured_count;
    logic              capture_valid;
    logic              write;
    logic [SLOT_W-1:0] slot_index;
    logic              pps_locked;
    logic              pps_missing;

    modport master (
        output sample_pulse, one_sec_pulse, enable,
        input  cic_pulse_counter, captured_count, capture_valid,
               write, slot_index, pps_locked, pps_missing
    );

    modport slave (
        input  sample_pulse, one_sec_pulse, enable,
        output cic_pulse_counter, captured_count, capture_valid,
               write, slot_index, pps_locked, pps_missing
    );
endinterface

// File: rtl/qpsk_timing_control_mc.sv
// ---------------------------------------------------------------------------
// qpsk_timing_control_mc
// Counts CIC sample strobes between PPS rising edges, captures each second's
// total, generates PPS-aligned symbol-slot write strobes every SLOT_LEN
// samples, qualifies PPS lock and flags a missing PPS.
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : qpsk_timing_control_mc_if.slave (strobes in, counters/status out)
// ---------------------------------------------------------------------------
module qpsk_timing_control_mc #(
    parameter int CNT_W     = 16,
    parameter int SLOT_LEN  = 40,
    parameter int SLOT_W    = 10,
    parameter int NOM_COUNT = 50,
    parameter int TOL       = 2,
    parameter int LOCK_N    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    qpsk_timing_control_mc_if.slave   bus
);
    localparam int LK_W = $clog2(LOCK_N + 1);
    localparam int PH_W = $clog2(SLOT_LEN);

    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(NOM_COUNT - TOL);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(NOM_COUNT + TOL);
    localparam logic [LK_W-1:0]  LOCK_MAX = LK_W'(LOCK_N);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SLOT_LEN - 1);

    typedef enum logic {SEARCH, LOCKED} lock_state_t;

    lock_state_t       state_q, state_n;
    logic [LK_W-1:0]   lock_cnt_q, lock_cnt_n;
    logic              pps_d;
    logic              first_seen;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cap_q;
    logic              cv_q;
    logic [PH_W-1:0]   phase_q;
    logic [SLOT_W-1:0] idx_q;
    logic              wr_q;
    logic              missing_q;

    logic pps_edge, qualify, in_range, overrun;

    assign pps_edge = bus.enable & bus.one_sec_pulse & ~pps_d;
    assign qualify  = pps_edge & first_seen;
    assign in_range = (cnt_q >= CNT_LO) && (cnt_q <= CNT_HI);
    // The sample that would push the count past the window, with no edge.
    assign overrun  = bus.enable & ~pps_edge & bus.sample_pulse & (cnt_q >= CNT_HI);

    always_comb begin
        state_n    = state_q;
        lock_cnt_n = lock_cnt_q;
        if (qualify) begin
            if (in_range) begin
                lock_cnt_n = (lock_cnt_q >= LOCK_MAX) ? LOCK_MAX : lock_cnt_q + LK_W'(1);
                if (lock_cnt_n == LOCK_MAX) begin
                    state_n = LOCKED;
                end
            end else begin
                lock_cnt_n = '0;
                state_n    = SEARCH;
            end
        end else if (overrun) begin
            lock_cnt_n = '0;
            state_n    = SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SEARCH;
            lock_cnt_q <= '0;
            pps_d      <= 1'b1;
            first_seen <= 1'b0;
            cnt_q      <= '0;
            cap_q      <= '0;
            cv_q       <= 1'b0;
            phase_q    <= '0;
            idx_q      <= '0;
            wr_q       <= 1'b0;
            missing_q  <= 1'b0;
        end else begin
            pps_d      <= bus.one_sec_pulse;
            state_q    <= state_n;
            lock_cnt_q <= lock_cnt_n;
            cv_q       <= 1'b0;
            wr_q       <= 1'b0;
            if (bus.enable) begin
                if (pps_edge) begin
                    // A coincident sample opens the new second and its first slot.
                    cap_q      <= cnt_q;
                    cv_q       <= first_seen;
                    first_seen <= 1'b1;
                    cnt_q      <= CNT_W'(bus.sample_pulse);
                    phase_q    <= PH_W'(bus.sample_pulse);
                    idx_q      <= '0;
                    missing_q  <= 1'b0;
                end else if (bus.sample_pulse) begin
                    if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    if (overrun) begin
                        missing_q <= 1'b1;
                    end
                    if (phase_q == PH_LAST) begin
                        phase_q <= '0;
                        wr_q    <= 1'b1;
                        idx_q   <= idx_q + SLOT_W'(1);
                    end else begin
                        phase_q <= phase_q + PH_W'(1);
                    end
                end
            end
        end
    end

    assign bus.cic_pulse_counter = cnt_q;
    assign bus.captured_count    = cap_q;
    assign bus.capture_valid     = cv_q;
    assign bus.write             = wr_q;
    assign bus.slot_index        = idx_q;
    assign bus.pps_locked        = (state_q == LOCKED);
    assign bus.pps_missing       = missing_q;
endmodule

// File: tb/tb_qpsk_timing_control_mc.sv
// ---------------------------------------------------------------------------
// tb_qpsk_timing_control_mc
// Directed bench for qpsk_timing_control_mc with SLOT_LEN=10: a cycle-by-cycle
// vector table for reset/edge/enable corners, then hand-built seconds for
// slot strobes, lock qualification, missing PPS, freeze and mid-run reset.
// ---------------------------------------------------------------------------
module tb_qpsk_timing_control_mc;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   k      = 0;   // samples delivered since the last PPS edge

    qpsk_timing_control_mc_if #(.CNT_W(16), .SLOT_W(10)) bus ();

    qpsk_timing_control_mc #(
        .CNT_W(16), .SLOT_LEN(10), .SLOT_W(10),
        .NOM_COUNT(50), .TOL(2), .LOCK_N(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic r, s, p, en;
        int   cnt, cap, cv, wr, idx, lock, miss;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input logic s, input logic p);
        bus.sample_pulse  = s;
        bus.one_sec_pulse = p;
        @(posedge clk);
        #1;
    endtask

    // One sample followed by an idle cycle; write must follow every 10th sample.
    task automatic one_sample(input int pre_lock);
        tick(1'b1, 1'b0);
        k++;
        chk("cnt", 32'(bus.cic_pulse_counter), k);
        chk("write", 32'(bus.write), (k % 10 == 0) ? 1 : 0);
        if (k % 10 == 0) chk("slot_index", 32'(bus.slot_index), k / 10);
        chk("missing", 32'(bus.pps_missing), (k >= 53) ? 1 : 0);
        chk("locked", 32'(bus.pps_locked), (k >= 53) ? 0 : pre_lock);
        tick(1'b0, 1'b0);
        chk("write_idle", 32'(bus.write), 0);
    endtask

    // n samples, then a PPS edge (optionally carrying a coincident sample).
    task automatic second(input int n, input int coin, input int exp_cv,
                          input int pre_lock, input int post_lock);
        int exp_cap;
        for (int i = 0; i < n; i++) one_sample(pre_lock);
        exp_cap = k;
        tick(coin != 0, 1'b1);
        chk("edge_cap", 32'(bus.captured_count), exp_cap);
        chk("edge_cv", 32'(bus.capture_valid), exp_cv);
        chk("edge_lock", 32'(bus.pps_locked), post_lock);
        chk("edge_cnt", 32'(bus.cic_pulse_counter), coin);
        chk("edge_write", 32'(bus.write), 0);
        chk("edge_idx", 32'(bus.slot_index), 0);
        chk("edge_missing", 32'(bus.pps_missing), 0);
        k = coin;
        tick(1'b0, 1'b0);
        chk("post_cv", 32'(bus.capture_valid), 0);
        chk("post_write", 32'(bus.write), 0);
        chk("post_lock", 32'(bus.pps_locked), post_lock);
    endtask

    initial begin
        //          r  s  p  en  cnt cap cv wr idx lk ms
        vecs[0]  = '{1, 0, 1, 1,  0,  0, 0, 0, 0, 0, 0};  // reset, PPS high
        vecs[1]  = '{0, 1, 1, 1,  1,  0, 0, 0, 0, 0, 0};  // PPS high at release: no edge
        vecs[2]  = '{0, 0, 1, 1,  1,  0, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, 1,  2,  0, 0, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 1, 1,  0,  2, 0, 0, 0, 0, 0};  // first edge: load, no valid
        vecs[5]  = '{0, 1, 1, 1,  1,  2, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 0, 1,  2,  2, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 1, 1, 1,  1,  2, 1, 0, 0, 0, 0};  // edge with coincident sample
        vecs[8]  = '{0, 0, 1, 1,  1,  2, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, 0,  1,  2, 0, 0, 0, 0, 0};  // disabled sample ignored
        vecs[10] = '{0, 1, 1, 0,  1,  2, 0, 0, 0, 0, 0};  // disabled edge ignored
        vecs[11] = '{0, 0, 1, 1,  1,  2, 0, 0, 0, 0, 0};  // level still high: no edge
        vecs[12] = '{0, 1, 0, 1,  2,  2, 0, 0, 0, 0, 0};
        vecs[13] = '{0, 0, 1, 1,  0,  2, 1, 0, 0, 0, 0};

        rst = 1'b1;
        bus.enable = 1'b1;
        bus.sample_pulse = 1'b0;
        bus.one_sec_pulse = 1'b0;

        for (int i = 0; i < 14; i++) begin
            rst = vecs[i].r;
            bus.enable = vecs[i].en;
            tick(vecs[i].s, vecs[i].p);
            chk("v_cnt", 32'(bus.cic_pulse_counter), vecs[i].cnt);
            chk("v_cap", 32'(bus.captured_count), vecs[i].cap);
            chk("v_cv", 32'(bus.capture_valid), vecs[i].cv);
            chk("v_write", 32'(bus.write), vecs[i].wr);
            chk("v_idx", 32'(bus.slot_index), vecs[i].idx);
            chk("v_lock", 32'(bus.pps_locked), vecs[i].lock);
            chk("v_missing", 32'(bus.pps_missing), vecs[i].miss);
        end

        // Clean start for the per-second sequences.
        rst = 1'b1;
        bus.enable = 1'b1;
        tick(1'b0, 1'b0);
        rst = 1'b0;
        tick(1'b0, 1'b0);
        k = 0;
        second(0,  0, 0, 0, 0);   // first edge after reset, no valid
        second(51, 0, 1, 0, 0);   // lock_cnt 1
        second(52, 0, 1, 0, 0);   // upper bound in range, lock_cnt 2
        second(51, 0, 1, 0, 1);   // third qualified capture locks
        second(40, 0, 1, 1, 0);   // early PPS drops lock
        second(49, 1, 1, 0, 0);   // coincident sample completes a slot: write suppressed
        second(50, 0, 1, 0, 0);   // 1+50 = 51 captured
        second(48, 0, 1, 0, 1);   // lower bound in range, relock
        second(60, 0, 1, 1, 0);   // PPS late: missing at 53rd sample, capture out of range

        // Freeze for 1000 clk with activity on the inputs.
        for (int i = 0; i < 5; i++) one_sample(0);
        bus.enable = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick((i % 2) == 1, (i % 100) < 50);
            chk("frz_cnt", 32'(bus.cic_pulse_counter), 5);
            chk("frz_write", 32'(bus.write), 0);
            chk("frz_cv", 32'(bus.capture_valid), 0);
            chk("frz_idx", 32'(bus.slot_index), 0);
        end
        bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) one_sample(0);   // resumes: write at k=10, index 1

        // Mid-run reset with PPS held high through release.
        rst = 1'b1;
        tick(1'b0, 1'b1);
        chk("rst_cnt", 32'(bus.cic_pulse_counter), 0);
        chk("rst_cap", 32'(bus.captured_count), 0);
        chk("rst_idx", 32'(bus.slot_index), 0);
        chk("rst_lock", 32'(bus.pps_locked), 0);
        rst = 1'b0;
        tick(1'b1, 1'b1);
        chk("rel_cnt", 32'(bus.cic_pulse_counter), 1);
        chk("rel_cv", 32'(bus.capture_valid), 0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("rel_edge_cap", 32'(bus.captured_count), 1);
        chk("rel_edge_cv", 32'(bus.capture_valid), 0);
        chk("rel_edge_cnt", 32'(bus.cic_pulse_counter), 0);
        tick(1'b0, 1'b0);
        chk("rel_post_cv", 32'(bus.capture_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qpsk_timing_control_mc.md
Name: qpsk_timing_control_mc

Overview:
- Parametrised successor to the QPSK timing controller.
- Counts CIC-output sample strobes between rising edges of the one-second pulse, and captures each second's total with a one-cycle valid strobe.
- Generates PPS-aligned symbol-slot write strobes every SLOT_LEN samples.
- Adds PPS lock qualification and missing-PPS detection for the QPSK framer and the PS-side logger.

Parameters:
CNT_W, 16, width of sample counters and captured count
SLOT_LEN, 40, samples per symbol slot (>=2)
SLOT_W, 10, width of slot_index
NOM_COUNT, 50, nominal samples per second
TOL, 2, allowed deviation of a captured count from NOM_COUNT
LOCK_N, 3, consecutive in-tolerance seconds required to assert pps_locked (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
sample_pulse  in  1  one-cycle CIC output strobe, synchronous to clk
one_sec_pulse  in  1  PPS level, already synchronised to clk, may stay high many cycles
enable  in  1  0 freezes all counters; edge detector keeps tracking
cic_pulse_counter  out  CNT_W  samples since last PPS edge, running
captured_count  out  CNT_W  samples in the previous complete second
capture_valid  out  1  one-cycle strobe, captured_count updated
write  out  1  one-cycle slot strobe
slot_index  out  SLOT_W  slot number since last PPS edge
pps_locked  out  1  PPS qualified
pps_missing  out  1  count exceeded NOM_COUNT+TOL without PPS

Behaviour:
- Reset values:
  - all outputs 0;
  - internal pps_d=1, so a PPS level already high at reset release is not an edge;
  - first_seen=0, lock_cnt=0, slot_phase=0.
- Edge detection: pps_edge = one_sec_pulse & ~pps_d, with pps_d registered every cycle. When enable=0, edges are ignored.
- Sample count (enable=1):
  - On pps_edge, captured_count <= cic_pulse_counter and cic_pulse_counter <= (sample_pulse ? 1 : 0). A coincident sample belongs to the new second.
  - Otherwise a sample_pulse increments cic_pulse_counter. It saturates at 2^CNT_W-1 and never wraps.
- capture_valid: high the cycle after pps_edge, but only when first_seen=1. The first edge after reset sets first_seen and produces no capture_valid; captured_count still loads.
- Slot generation:
  - slot_phase counts samples from 0 to SLOT_LEN-1.
  - When a sample arrives at slot_phase=SLOT_LEN-1: phase goes to 0, write=1 next cycle, and slot_index increments, wrapping at 2^SLOT_W.
  - The first write after a PPS edge carries slot_index=1.
  - On pps_edge: slot_phase <= (sample_pulse ? 1 : 0), slot_index <= 0, and write is suppressed that cycle even if a slot would complete. PPS has priority.
  - Latency: write rises exactly 1 clk after the completing sample_pulse.
- Lock state machine (evaluated on each qualified capture):
  - States are SEARCH (pps_locked=0) and LOCKED (pps_locked=1).
  - In range means NOM_COUNT-TOL <= count <= NOM_COUNT+TOL.
  - In range: lock_cnt increments, saturating at LOCK_N. On reaching LOCK_N, go to LOCKED.
  - Out of range: lock_cnt <= 0, state SEARCH.
  - pps_locked changes in the same cycle as capture_valid.
- Missing PPS:
  - When cic_pulse_counter would exceed NOM_COUNT+TOL without an edge: pps_missing <= 1, lock_cnt <= 0, state SEARCH.
  - pps_missing clears on the next pps_edge.
  - Slot generation keeps free-running while pps_missing=1.
- enable=0: counters, slot logic and lock state hold their values. write and capture_valid are forced 0.
- Reset mid-operation: all state returns to reset values on the next clk. A PPS held high through reset release produces no edge until it falls and rises again.

Test Plan:
- Reset release with PPS already high -> no capture_valid, cic_pulse_counter counts from 0.
- Sample every 320 clk, PPS rising every 16500 clk, defaults except SLOT_LEN=10 -> first edge gives no capture_valid. Later captures are 51 or 52, so in range. pps_locked rises with the 3rd qualified capture.
- Steady sampling -> write 1 clk after every 10th sample, slot_index 1..5 per second. Reset to 0 at each edge; no write in an edge cycle.
- sample_pulse coincident with pps_edge -> captured_count excludes it, cic_pulse_counter=1, slot_phase=1.
- PPS removed while locked -> on the 53rd sample, pps_missing=1 and pps_locked=0. The next PPS edge clears pps_missing, and the capture is then out of range, so the state stays SEARCH.
- One capture of 40 (PPS early) while LOCKED -> pps_locked=0, lock_cnt restarts. Three further in-range seconds relock. enable=0 held for 1000 clk -> all counters frozen, no write.
